// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the serial pattern detector.
// Accepts WIDTH-bit words over valid/ready and presents one bit per clock on
// ser_out, with word-boundary flags, an optional idle gap and a word counter.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0,
    parameter int GAP       = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy,
    output logic [15:0]      word_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    GAP_LOAD = 4'((GAP > 0) ? (GAP - 1) : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bit_cnt;
    logic [3:0]       r_gap_cnt;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_first_bit;
    logic             r_last_bit;
    logic             r_busy;
    logic [15:0]      r_word_count;

    logic             w_accept;
    logic             w_load_first;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shift_next;

    // The shift register keeps the bit currently on ser_out at its output end,
    // so the following bit is always one position further in.
    assign w_load_first = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-2]   : r_shift[1];
    assign w_shift_next = MSB_FIRST ? (r_shift << 1)     : (r_shift >> 1);

    // Ready in IDLE, or in the final bit slot when no gap is required, so a
    // waiting word follows the previous one without a bubble.
    assign load_ready = reset && ((r_state == ST_IDLE) ||
                                  ((GAP == 0) && (r_state == ST_SHIFT) && r_last_bit));
    assign w_accept   = load_valid && load_ready;

    // Sequencer: accept words, step through the bits, then the optional gap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_ser_out    <= IDLE_BIT;
            r_ser_valid  <= 1'b0;
            r_first_bit  <= 1'b0;
            r_last_bit   <= 1'b0;
            r_busy       <= 1'b0;
            r_word_count <= '0;
        end else if (w_accept) begin
            r_state      <= ST_SHIFT;
            r_shift      <= load_data;
            r_bit_cnt    <= '0;
            r_ser_out    <= w_load_first;
            r_ser_valid  <= 1'b1;
            r_first_bit  <= 1'b1;
            r_last_bit   <= 1'b0;
            r_busy       <= 1'b1;
            r_word_count <= r_word_count + 16'd1;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (r_last_bit) begin
                        r_ser_out   <= IDLE_BIT;
                        r_ser_valid <= 1'b0;
                        r_first_bit <= 1'b0;
                        r_last_bit  <= 1'b0;
                        if (GAP > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_LOAD;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_shift     <= w_shift_next;
                        r_ser_out   <= w_next_bit;
                        r_first_bit <= 1'b0;
                        r_last_bit  <= ((r_bit_cnt + CNT_ONE) == LAST_IDX);
                        r_bit_cnt   <= r_bit_cnt + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign first_bit  = r_first_bit;
    assign last_bit   = r_last_bit;
    assign busy       = r_busy;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: three instances (MSB-first no gap, MSB-first
// gap of 2, LSB-first with idle level 1) checked every cycle against a
// queue-based reference model, plus a vector table and directed sequences.
module tb_bit_serializer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0]  ld  [3];
    logic        lv  [3];
    logic        rdy [3];
    logic        so  [3];
    logic        sv  [3];
    logic        fb  [3];
    logic        lb  [3];
    logic        bz  [3];
    logic [15:0] wc  [3];

    int cfg_gap  [3] = '{0, 2, 0};
    bit cfg_msb  [3] = '{1'b1, 1'b1, 1'b0};
    bit cfg_idle [3] = '{1'b0, 1'b0, 1'b1};

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(0)) u0 (
        .clock(clock), .reset(reset), .load_data(ld[0]), .load_valid(lv[0]),
        .load_ready(rdy[0]), .ser_out(so[0]), .ser_valid(sv[0]), .first_bit(fb[0]),
        .last_bit(lb[0]), .busy(bz[0]), .word_count(wc[0]));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(2)) u1 (
        .clock(clock), .reset(reset), .load_data(ld[1]), .load_valid(lv[1]),
        .load_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]), .first_bit(fb[1]),
        .last_bit(lb[1]), .busy(bz[1]), .word_count(wc[1]));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP(0)) u2 (
        .clock(clock), .reset(reset), .load_data(ld[2]), .load_valid(lv[2]),
        .load_ready(rdy[2]), .ser_out(so[2]), .ser_valid(sv[2]), .first_bit(fb[2]),
        .last_bit(lb[2]), .busy(bz[2]), .word_count(wc[2]));

    // Reference model: each instance owns a FIFO of future output cycles.
    typedef struct packed {
        logic so;
        logic sv;
        logic fb;
        logic lb;
        logic bz;
    } rec_t;

    rec_t        mbuf  [3][64];
    int          mhead [3] = '{0, 0, 0};
    int          mcnt  [3] = '{0, 0, 0};
    logic [15:0] mwc   [3] = '{16'd0, 16'd0, 16'd0};

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         d;
        logic [7:0] data;
        logic [7:0] exp_bits;   // transmit order, first bit at [7]
        logic       idle;
    } vec_t;

    function automatic bit m_ready(int d);
        return reset && ((mcnt[d] == 0) || ((cfg_gap[d] == 0) && (mcnt[d] == 1)));
    endfunction

    function automatic rec_t m_cur(int d);
        rec_t r;
        if (mcnt[d] > 0) begin
            r = mbuf[d][mhead[d]];
        end else begin
            r = '0;
            r.so = cfg_idle[d];
        end
        return r;
    endfunction

    task automatic m_clear();
        for (int d = 0; d < 3; d++) begin
            mcnt[d]  = 0;
            mhead[d] = 0;
            mwc[d]   = 16'd0;
        end
    endtask

    task automatic m_push(int d, rec_t r);
        mbuf[d][(mhead[d] + mcnt[d]) % 64] = r;
        mcnt[d]++;
    endtask

    task automatic m_step(int d);
        bit   acc;
        rec_t r;
        if (!reset) begin
            m_clear();
            return;
        end
        acc = lv[d] && m_ready(d);
        if (mcnt[d] > 0) begin
            mhead[d] = (mhead[d] + 1) % 64;
            mcnt[d]--;
        end
        if (acc) begin
            mwc[d] = mwc[d] + 16'd1;
            for (int i = 0; i < 8; i++) begin
                r.so = cfg_msb[d] ? ld[d][7-i] : ld[d][i];
                r.sv = 1'b1;
                r.fb = (i == 0);
                r.lb = (i == 7);
                r.bz = 1'b1;
                m_push(d, r);
            end
            for (int g = 0; g < cfg_gap[d]; g++) begin
                r = '0;
                r.so = cfg_idle[d];
                r.bz = 1'b1;
                m_push(d, r);
            end
        end
    endtask

    task automatic check(int d);
        logic [21:0] act;
        logic [21:0] exp;
        act = {rdy[d], so[d], sv[d], fb[d], lb[d], bz[d], wc[d]};
        exp = {m_ready(d), m_cur(d), mwc[d]};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL model dut%0d t=%0t rdy,so,sv,fb,lb,bz,wc got=%b required=%b",
                     d, $time, act, exp);
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic tick();
        @(posedge clock);
        for (int d = 0; d < 3; d++) m_step(d);
        @(negedge clock);
        for (int d = 0; d < 3; d++) check(d);
    endtask

    task automatic drain(int d);
        int n;
        n = 0;
        while (mcnt[d] != 0 && n < 64) begin
            tick();
            n++;
        end
        chk("drain_idle", 32'(mcnt[d]), 32'd0);
    endtask

    vec_t tv [5];

    initial begin
        logic [15:0] bits16;
        logic [11:0] svv;
        logic [11:0] rdyv;
        logic [15:0] wc_base;
        int          nvalid;

        tv[0] = '{d: 0, data: 8'hA5, exp_bits: 8'b10100101, idle: 1'b0};
        tv[1] = '{d: 2, data: 8'h0E, exp_bits: 8'b01110000, idle: 1'b1};
        tv[2] = '{d: 0, data: 8'h3C, exp_bits: 8'b00111100, idle: 1'b0};
        tv[3] = '{d: 2, data: 8'h81, exp_bits: 8'b10000001, idle: 1'b1};
        tv[4] = '{d: 1, data: 8'h5A, exp_bits: 8'b01011010, idle: 1'b0};

        for (int d = 0; d < 3; d++) begin
            ld[d] = 8'h00;
            lv[d] = 1'b0;
        end

        // Reset state
        #2 reset = 1'b0;
        m_clear();
        #1;
        for (int d = 0; d < 3; d++) check(d);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Table of single words, including the A5 and 0E plan cases
        for (int t = 0; t < 5; t++) begin
            int d;
            d = tv[t].d;
            drain(d);
            chk($sformatf("idle_before_%0d", t), 32'(so[d]), 32'(tv[t].idle));
            ld[d] = tv[t].data;
            lv[d] = 1'b1;
            tick();
            lv[d] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("word%0d_bit%0d", t, i), 32'(so[d]), 32'(tv[t].exp_bits[7-i]));
                chk($sformatf("word%0d_first%0d", t, i), 32'(fb[d]), 32'(i == 0));
                chk($sformatf("word%0d_last%0d", t, i), 32'(lb[d]), 32'(i == 7));
                if (i < 7) tick();
            end
            for (int g = 0; g <= cfg_gap[d]; g++) tick();
            chk($sformatf("idle_after_%0d", t), 32'(so[d]), 32'(tv[t].idle));
            chk($sformatf("busy_after_%0d", t), 32'(bz[d]), 32'd0);
        end

        // Back-to-back on the no-gap instance: 80 then 01 with valid held
        drain(0);
        wc_base = mwc[0];
        bits16 = '0;
        nvalid = 0;
        ld[0] = 8'h80;
        lv[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 0) ld[0] = 8'h01;
            if (k == 8) begin
                lv[0] = 1'b0;
                chk("b2b_first_second_word", 32'(fb[0]), 32'd1);
            end
            if (k == 7) chk("b2b_ready_slot", 32'(rdy[0]), 32'd1);
            bits16[15-k] = so[0];
            if (sv[0]) nvalid++;
        end
        chk("b2b_bits", 32'(bits16), 32'h8001);
        chk("b2b_valid_cycles", 32'(nvalid), 32'd16);
        tick();
        chk("b2b_word_count", 32'(wc[0]), 32'(wc_base + 16'd2));

        // Gap of 2 cycles between two continuously presented words
        drain(1);
        svv  = '0;
        rdyv = '0;
        ld[1] = 8'hC3;
        lv[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 0) ld[1] = 8'h3C;
            svv[11-k]  = sv[1];
            rdyv[11-k] = rdy[1];
        end
        lv[1] = 1'b0;
        chk("gap_valid_pattern", 32'(svv), 32'b111111110001);
        chk("gap_ready_pattern", 32'(rdyv), 32'b000000000010);
        drain(1);

        // Reset pulse during bit 4 of FF, then a fresh word
        drain(0);
        ld[0] = 8'hFF;
        lv[0] = 1'b1;
        tick();
        lv[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_pre_bit4", 32'(so[0]), 32'd1);
        #2 reset = 1'b0;
        m_clear();
        #1;
        chk("rst_ser_out", 32'(so[0]), 32'd0);
        chk("rst_ser_valid", 32'(sv[0]), 32'd0);
        chk("rst_word_count", 32'(wc[0]), 32'd0);
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        for (int d = 0; d < 3; d++) check(d);
        @(negedge clock);
        tick();
        reset = 1'b1;
        ld[0] = 8'h96;
        lv[0] = 1'b1;
        tick();
        lv[0] = 1'b0;
        chk("post_rst_first_bit", 32'(so[0]), 32'd1);
        chk("post_rst_first_flag", 32'(fb[0]), 32'd1);
        tick();
        chk("post_rst_second_bit", 32'(so[0]), 32'd0);
        chk("post_rst_word_count", 32'(wc[0]), 32'd1);

        // Random traffic on all three instances with one reset pulse
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 3; d++) begin
                lv[d] = ($urandom_range(0, 3) != 0);
                ld[d] = 8'($urandom);
            end
            if (c == 1500) reset = 1'b0;
            if (c == 1502) reset = 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end for the serial pattern-detector FSM (`my_fsm`). It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on ser_out, which drives the detector's `in` input. Word-boundary flags and a word counter are provided for the surrounding logic and for the bench.

Parameters:
WIDTH, 8, word width in bits (legal range 2..32).
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_BIT, 0, level driven on ser_out whenever no data bit is being sent.
GAP, 0, number of idle cycles inserted after each word (legal range 0..15).

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
load_data  input  WIDTH  word to serialize; sampled only on acceptance.
load_valid  input  1  upstream has a word on load_data.
load_ready  output  1  block can accept a word this cycle.
ser_out  output  1  serial bit stream; feeds the detector's `in`.
ser_valid  output  1  ser_out carries a data bit this cycle.
first_bit  output  1  high while the first bit of a word is on ser_out.
last_bit  output  1  high while the last bit of a word is on ser_out.
busy  output  1  high in SHIFT or GAP.
word_count  output  16  number of words accepted since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - ser_out=IDLE_BIT; ser_valid=0, first_bit=0, last_bit=0, busy=0.
  - word_count=0; load_ready=0 while reset is asserted.
- Acceptance: load_valid && load_ready at a rising edge. load_data is captured into the shift register and word_count increments (wraps 0xFFFF->0x0000).
- States:
  - IDLE:
    - load_ready=1; ser_out=IDLE_BIT; ser_valid=0.
    - On acceptance -> SHIFT.
  - SHIFT:
    - ser_valid=1; one bit is presented per cycle for exactly WIDTH cycles.
    - Latency: the first bit is on ser_out in the cycle immediately after the accepting edge.
    - first_bit=1 in the first SHIFT cycle; last_bit=1 in the WIDTH-th cycle.
    - When WIDTH=... note that first_bit and last_bit are never simultaneous, because WIDTH>=2.
    - After the last bit: GAP>0 -> GAP; GAP=0 -> IDLE, unless a back-to-back accept occurs.
  - GAP:
    - ser_out=IDLE_BIT; ser_valid=0; load_ready=0.
    - Lasts exactly GAP cycles, then -> IDLE.
- load_ready is combinational: reset && (state==IDLE || (GAP==0 && state==SHIFT && last_bit)).
- Back-to-back (GAP=0): an acceptance during the last_bit cycle reloads the shift register. The next word's first bit follows with no idle cycle, state stays SHIFT, and first_bit=1 in the next cycle.
- Data stability: load_data and load_valid changes while not accepting have no effect. The captured word is immune to later load_data changes.
- Holding load_valid high with no word pending is legal: each acceptance consumes exactly one word.
- Asserting reset mid-word aborts the word immediately and forces all outputs to their reset values asynchronously. The partially sent word is not resumed after reset is released.
- Outputs ser_out, ser_valid, first_bit, last_bit, busy and word_count are registered; there is no combinational path from inputs to these outputs.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: accept 8'hA5.
   -> Cycles 1..8 after the accepting edge: ser_out = 1,0,1,0,0,1,0,1.
   -> first_bit in cycle 1, last_bit in cycle 8, ser_valid=1 for exactly 8 cycles.
   -> Then ser_out=0, busy=0, word_count=1.
2. Back-to-back, GAP=0: 8'h80, then 8'h01 held valid.
   -> 16 continuous valid bits: 1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1.
   -> load_ready high only in IDLE and in the cycle-8 slot; word_count=2.
3. GAP=2: two words presented continuously.
   -> 8 data bits, then 2 cycles with ser_valid=0 and ser_out=IDLE_BIT, then 1 IDLE cycle before the next word's first bit.
4. MSB_FIRST=0, IDLE_BIT=1: accept 8'h0E.
   -> ser_out = 0,1,1,1,0,0,0,0; idle level is 1 before and after the word.
5. Reset pulse (reset=0 for 1 cycle) during bit 4 of 8'hFF.
   -> ser_out drops to IDLE_BIT at once, ser_valid=0, word_count=0.
   -> A new word accepted after release serializes from its first bit.
6. Wrap: accept 65536 words.
   -> word_count returns to 0x0000; no other output disturbed.
